// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for a multi-cycle RV32I datapath.
// Sequences fetch/decode/execute/memory/write-back over a shared ALU and a
// unified memory port, with memory wait-state timeout and illegal-opcode traps.
module multicycle_ctrl #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Count value at which one more not-ready cycle means timeout.
  localparam logic [7:0] LIMIT_M1 = 8'(WAIT_LIMIT - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_next;
  logic [1:0] r_cause;
  logic [1:0] w_cause_next;
  logic       w_wait_state;
  logic       w_timeout;

  // Only funct3[0] distinguishes BEQ from BNE; the other bits are don't-care.
  logic w_unused_funct3;
  assign w_unused_funct3 = ^funct3[2:1];

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // Completion (mem_ready=1) always wins over timeout.
  assign w_timeout    = w_wait_state && !mem_ready && (r_wait_cnt == LIMIT_M1);

  assign state      = r_state;
  assign trap       = reset && (r_state == S_TRAP);
  assign trap_cause = r_cause;

  // State, wait counter and trap cause registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_FETCH;
      r_wait_cnt <= 8'd0;
      r_cause    <= 2'b00;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_next;
      r_cause    <= w_cause_next;
    end
  end

  // Next-state decode and Moore (plus mem_ready/zero qualified) outputs.
  always_comb begin
    w_next       = r_state;
    w_cause_next = r_cause;
    w_wait_next  = 8'd0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    ir_write     = 1'b0;
    iord         = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    retire       = 1'b0;

    case (r_state)
      S_FETCH: begin
        if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_R:              w_next = S_EXEC_R;
          OP_I:              w_next = S_EXEC_I;
          OP_LOAD, OP_STORE: w_next = S_MEM_ADDR;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          default: begin
            w_next       = S_TRAP;
            w_cause_next = 2'b01;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
      S_MEM_ADDR:         w_next = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:           if (mem_ready) w_next = S_WB_MEM;
      S_MEM_WR:           if (mem_ready) w_next = S_FETCH;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: w_next = S_FETCH;
      default:            w_next = S_TRAP;
    endcase

    // Wait-state accounting; the counter is zero whenever a wait state is entered.
    if (w_timeout) begin
      w_next       = S_TRAP;
      w_cause_next = 2'b10;
    end else if (w_wait_state && !mem_ready) begin
      w_wait_next = r_wait_cnt + 8'd1;
    end

    // Control outputs are held at zero while reset is asserted.
    if (reset) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b10;
        end
        S_EXEC_R: begin
          alu_src_a = 2'b01;
          alu_op    = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          alu_op    = 2'b10;
        end
        S_MEM_ADDR: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          retire    = mem_ready;
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 2'b01;
          alu_op    = 2'b01;
          pc_src    = 1'b1;
          retire    = 1'b1;
          pc_write  = zero ^ funct3[0];
        end
        S_JAL: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          reg_write = 1'b1;
          pc_write  = 1'b1;
          pc_src    = 1'b1;
          retire    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
